// File: rtl/latch_deser.sv
// latch_deser: deserializer downstream of the NAND cross-coupled latch.
//
// Brings the complementary latch outputs qa/qb into the clock domain,
// qualifies each sample by complementarity and stability, packs accepted
// bits LSB-first into WORD_W-bit words, and hands each word downstream over
// a registered valid/ready handshake. It also reports rejected samples and
// overflow.
//
// Ports:
//   clock      in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   qa, qb     in   latch true/complement outputs (asynchronous)
//   sample_en  in   one-cycle strobe: sample the synchronized bit now
//   clr_err    in   clears ovf and err_cnt on the next cycle
//   out_ready  in   downstream accepts out_data this cycle
//   out_data   out  packed word, first accepted bit at bit 0
//   out_valid  out  out_data holds an unconsumed word
//   bit_err    out  one-cycle pulse after a rejected sample
//   err_cnt    out  saturating count of rejected samples
//   ovf        out  sticky: a sample arrived while a word was held back
module latch_deser #(
  parameter int WORD_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYC  = 2
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              qa,
  input  logic              qb,
  input  logic              sample_en,
  input  logic              clr_err,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  output logic              bit_err,
  output logic [7:0]        err_cnt,
  output logic              ovf
);

  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WORD_W);
  localparam logic [3:0]       STAB_MIN = 4'(STABLE_CYC);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Saturating increment helpers for the stability and error counters.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    if (v == 4'd15) begin
      sat_inc4 = 4'd15;
    end else begin
      sat_inc4 = v + 4'd1;
    end
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'd255) begin
      sat_inc8 = 8'd255;
    end else begin
      sat_inc8 = v + 8'd1;
    end
  endfunction

  logic [SYNC_STAGES-1:0] qa_sync_r;
  logic [SYNC_STAGES-1:0] qb_sync_r;
  logic                   qa_s;
  logic                   qb_s;
  logic                   valid_s;
  logic                   prev_qa_r;
  logic                   prev_valid_r;
  logic [3:0]             stab_r;
  logic [3:0]             stab_nxt_s;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [WORD_W-1:0]      shreg_r;
  logic [WORD_W-1:0]      shreg_nxt_s;
  logic [WORD_W-1:0]      shifted_s;
  logic [CNT_W-1:0]       bit_cnt_r;
  logic [CNT_W-1:0]       bit_cnt_nxt_s;
  logic [WORD_W-1:0]      out_data_r;
  logic [WORD_W-1:0]      out_data_nxt_s;
  logic                   out_valid_r;
  logic                   out_valid_nxt_s;
  logic                   bit_err_r;
  logic [7:0]             err_cnt_r;
  logic [7:0]             err_cnt_nxt_s;
  logic                   ovf_r;
  logic                   ovf_nxt_s;

  logic                   accept_s;
  logic                   reject_s;
  logic                   ovf_evt_s;
  logic                   xfer_s;

  assign qa_s      = qa_sync_r[SYNC_STAGES-1];
  assign qb_s      = qb_sync_r[SYNC_STAGES-1];
  assign valid_s   = qa_s ^ qb_s;
  assign shifted_s = {qa_s, shreg_r[WORD_W-1:1]};

  assign accept_s  = sample_en && (state_r == FILL) && (stab_nxt_s >= STAB_MIN);
  assign reject_s  = sample_en && (state_r == FILL) && (stab_nxt_s <  STAB_MIN);
  assign ovf_evt_s = sample_en && (state_r == HOLD);
  assign xfer_s    = out_valid_r && out_ready;

  // Metastability synchronizers for the asynchronous latch outputs.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      qa_sync_r <= '0;
      qb_sync_r <= '0;
    end else begin
      qa_sync_r <= {qa_sync_r[SYNC_STAGES-2:0], qa};
      qb_sync_r <= {qb_sync_r[SYNC_STAGES-2:0], qb};
    end
  end

  // Stability next value: restarts at 1 whenever the bit changes or becomes valid.
  always_comb begin
    stab_nxt_s = 4'd0;
    if (!valid_s) begin
      stab_nxt_s = 4'd0;
    end else if ((qa_s == prev_qa_r) && prev_valid_r) begin
      stab_nxt_s = sat_inc4(stab_r);
    end else begin
      stab_nxt_s = 4'd1;
    end
  end

  // Stability tracking registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      prev_qa_r    <= 1'b0;
      prev_valid_r <= 1'b0;
      stab_r       <= 4'd0;
    end else begin
      prev_qa_r    <= qa_s;
      prev_valid_r <= valid_s;
      stab_r       <= stab_nxt_s;
    end
  end

  // Next-state, packing and output-slot logic.
  always_comb begin
    state_nxt_s     = state_r;
    shreg_nxt_s     = shreg_r;
    bit_cnt_nxt_s   = bit_cnt_r;
    out_data_nxt_s  = out_data_r;
    out_valid_nxt_s = out_valid_r;
    if (xfer_s) begin
      out_valid_nxt_s = 1'b0;
    end else begin
      out_valid_nxt_s = out_valid_r;
    end
    case (state_r)
      FILL: begin
        if (accept_s) begin
          shreg_nxt_s = shifted_s;
          if (bit_cnt_r == LAST_IDX) begin
            // Word complete: load the slot if it is free or draining now.
            if (!out_valid_r || out_ready) begin
              out_data_nxt_s  = shifted_s;
              out_valid_nxt_s = 1'b1;
              bit_cnt_nxt_s   = '0;
            end else begin
              bit_cnt_nxt_s = FULL_CNT;
              state_nxt_s   = HOLD;
            end
          end else begin
            bit_cnt_nxt_s = bit_cnt_r + CNT_W'(1);
          end
        end else begin
          shreg_nxt_s = shreg_r;
        end
      end
      HOLD: begin
        // Held word follows the outgoing one with no bubble.
        if (xfer_s) begin
          out_data_nxt_s  = shreg_r;
          out_valid_nxt_s = 1'b1;
          bit_cnt_nxt_s   = '0;
          state_nxt_s     = FILL;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = FILL;
      end
    endcase
  end

  // Error counter and overflow flag next values; clr_err loses to a coinciding event.
  always_comb begin
    err_cnt_nxt_s = err_cnt_r;
    ovf_nxt_s     = ovf_r;
    if (clr_err) begin
      if (reject_s) begin
        err_cnt_nxt_s = 8'd1;
      end else begin
        err_cnt_nxt_s = 8'd0;
      end
    end else if (reject_s) begin
      err_cnt_nxt_s = sat_inc8(err_cnt_r);
    end else begin
      err_cnt_nxt_s = err_cnt_r;
    end
    if (ovf_evt_s) begin
      ovf_nxt_s = 1'b1;
    end else if (clr_err) begin
      ovf_nxt_s = 1'b0;
    end else begin
      ovf_nxt_s = ovf_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FILL;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      shreg_r     <= '0;
      bit_cnt_r   <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      bit_err_r   <= 1'b0;
      err_cnt_r   <= 8'd0;
      ovf_r       <= 1'b0;
    end else begin
      shreg_r     <= shreg_nxt_s;
      bit_cnt_r   <= bit_cnt_nxt_s;
      out_data_r  <= out_data_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      bit_err_r   <= reject_s;
      err_cnt_r   <= err_cnt_nxt_s;
      ovf_r       <= ovf_nxt_s;
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign bit_err   = bit_err_r;
  assign err_cnt   = err_cnt_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_latch_deser.sv
// Self-checking bench for latch_deser with default parameters
// (WORD_W=8, SYNC_STAGES=2, STABLE_CYC=2). Inputs change on the falling
// edge and outputs are sampled on the falling edge.
module tb_latch_deser;

  logic       clock;
  logic       rst_n;
  logic       qa;
  logic       qb;
  logic       sample_en;
  logic       clr_err;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       bit_err;
  logic [7:0] err_cnt;
  logic       ovf;

  int n_checks = 0;
  int n_fail   = 0;

  latch_deser dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .qa        (qa),
    .qb        (qb),
    .sample_en (sample_en),
    .clr_err   (clr_err),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .bit_err   (bit_err),
    .err_cnt   (err_cnt),
    .ovf       (ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Strobe order is written left to right (first strobe = leftmost bit);
  // exp is the word after LSB-first packing, worked out by hand.
  typedef struct {
    logic [7:0] seq;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic strobe();
    sample_en = 1'b1;
    cyc();
    sample_en = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    qa = b;
    qb = ~b;
    repeat (4) cyc();
    strobe();
  endtask

  task automatic send_bad();
    qa = 1'b1;
    qb = 1'b1;
    repeat (4) cyc();
    strobe();
  endtask

  task automatic send_seq(input logic [7:0] seq);
    for (int i = 7; i >= 0; i--) send_bit(seq[i]);
  endtask

  initial begin
    vecs[0] = '{seq: 8'b10110010, exp: 8'h4D};
    vecs[1] = '{seq: 8'b11111111, exp: 8'hFF};
    vecs[2] = '{seq: 8'b00000000, exp: 8'h00};
    vecs[3] = '{seq: 8'b10000000, exp: 8'h01};
    vecs[4] = '{seq: 8'b00000001, exp: 8'h80};
    vecs[5] = '{seq: 8'b11001010, exp: 8'h53};
    vecs[6] = '{seq: 8'b01101001, exp: 8'h96};

    rst_n     = 1'b1;
    qa        = 1'b1;
    qb        = 1'b0;
    sample_en = 1'b0;
    clr_err   = 1'b0;
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("reset out_data",  32'(out_data),  32'h0);
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset bit_err",   32'(bit_err),   32'h0);
    check("reset err_cnt",   32'(err_cnt),   32'h0);
    check("reset ovf",       32'(ovf),       32'h0);
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (10) cyc();
    check("idle out_valid", 32'(out_valid), 32'h0);

    // Table-driven word packing with the output always ready.
    for (int v = 0; v < 7; v++) begin
      for (int i = 7; i >= 1; i--) send_bit(vecs[v].seq[i]);
      check($sformatf("vec%0d valid before last bit", v), 32'(out_valid), 32'h0);
      send_bit(vecs[v].seq[0]);
      check($sformatf("vec%0d out_valid", v), 32'(out_valid), 32'h1);
      check($sformatf("vec%0d out_data", v),  32'(out_data),  32'(vecs[v].exp));
      cyc();
      check($sformatf("vec%0d valid one cycle", v), 32'(out_valid), 32'h0);
    end
    check("pack err_cnt", 32'(err_cnt), 32'h0);

    // Invalid latch state on the 3rd strobe: 9 strobes, 8 good bits.
    send_bit(1'b1);
    send_bit(1'b0);
    send_bad();
    check("bad bit_err",  32'(bit_err), 32'h1);
    check("bad err_cnt",  32'(err_cnt), 32'h1);
    cyc();
    check("bad bit_err pulse", 32'(bit_err), 32'h0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    check("bad valid before 9th", 32'(out_valid), 32'h0);
    send_bit(1'b0);
    check("bad word valid", 32'(out_valid), 32'h1);
    check("bad word data",  32'(out_data),  32'h4D);

    // Stability: synchronized bit has changed only in the strobe cycle -> reject.
    qa = 1'b1;
    qb = 1'b0;
    repeat (2) cyc();
    strobe();
    check("unstable bit_err", 32'(bit_err), 32'h1);
    check("unstable err_cnt", 32'(err_cnt), 32'h2);
    // Changed one cycle earlier -> two stable cycles -> accepted.
    qa = 1'b0;
    qb = 1'b1;
    repeat (3) cyc();
    strobe();
    check("stable bit_err", 32'(bit_err), 32'h0);
    check("stable err_cnt", 32'(err_cnt), 32'h2);
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    check("stable word valid", 32'(out_valid), 32'h1);
    check("stable word data",  32'(out_data),  32'hFE);
    cyc();

    // Backpressure and overflow.
    out_ready = 1'b0;
    send_seq(8'b10110010);
    check("bp word1 valid", 32'(out_valid), 32'h1);
    check("bp word1 data",  32'(out_data),  32'h4D);
    send_seq(8'b11001010);
    check("bp hold valid", 32'(out_valid), 32'h1);
    check("bp hold data",  32'(out_data),  32'h4D);
    check("bp hold ovf",   32'(ovf),       32'h0);
    send_bit(1'b1);
    check("ovf set",     32'(ovf),     32'h1);
    check("ovf bit_err", 32'(bit_err), 32'h0);
    check("ovf err_cnt", 32'(err_cnt), 32'h2);
    out_ready = 1'b1;
    cyc();
    check("b2b word2 valid", 32'(out_valid), 32'h1);
    check("b2b word2 data",  32'(out_data),  32'h53);
    cyc();
    check("b2b drained", 32'(out_valid), 32'h0);
    check("ovf sticky",  32'(ovf),       32'h1);
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    check("clr ovf",     32'(ovf),     32'h0);
    check("clr err_cnt", 32'(err_cnt), 32'h0);

    // err_cnt saturation, then clr_err coinciding with a reject.
    qa = 1'b1;
    qb = 1'b1;
    repeat (4) cyc();
    sample_en = 1'b1;
    repeat (260) cyc();
    check("sat err_cnt", 32'(err_cnt), 32'd255);
    check("sat bit_err", 32'(bit_err), 32'h1);
    clr_err = 1'b1;
    cyc();
    clr_err   = 1'b0;
    sample_en = 1'b0;
    check("clr+reject err_cnt", 32'(err_cnt), 32'h1);
    cyc();
    check("post clr err_cnt", 32'(err_cnt), 32'h1);
    check("post clr bit_err", 32'(bit_err), 32'h0);
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    check("clr2 err_cnt", 32'(err_cnt), 32'h0);

    // Reset mid-operation with a word pending and a partial word collected.
    out_ready = 1'b0;
    send_seq(8'b11111111);
    check("pre-rst valid", 32'(out_valid), 32'h1);
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst async out_valid", 32'(out_valid), 32'h0);
    check("rst async out_data",  32'(out_data),  32'h0);
    @(negedge clock);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 7; i >= 1; i--) send_bit(vecs[6].seq[i]);
    check("post-rst no early word", 32'(out_valid), 32'h0);
    send_bit(vecs[6].seq[0]);
    check("post-rst valid", 32'(out_valid), 32'h1);
    check("post-rst data",  32'(out_data),  32'h96);
    check("post-rst err_cnt", 32'(err_cnt), 32'h0);
    check("post-rst ovf",     32'(ovf),     32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/latch_deser.md
Name: latch_deser

Overview:
- Downstream consumer of the NAND cross-coupled latch (complementary outputs qa/qb) in the k-means datapath.
- Synchronizes qa/qb into the clock domain and checks that they are complementary and stable.
- Samples one bit per sample_en strobe and packs WORD_W bits into a word.
- Hands the word to the feature-load logic over a valid/ready handshake, with error and overflow reporting.

Parameters:
- WORD_W, 8: bits per output word; range 2..32.
- SYNC_STAGES, 2: synchronizer depth on qa and on qb; minimum 2.
- STABLE_CYC, 2: consecutive valid, unchanged synchronized cycles a bit needs before a sample is accepted; range 1..15.

Ports:
- clock  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- qa  in  1  latch true output, asynchronous.
- qb  in  1  latch complement output, asynchronous.
- sample_en  in  1  one-cycle strobe: sample the synchronized bit this cycle.
- clr_err  in  1  clears the sticky flags and err_cnt.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  WORD_W  packed word; the first accepted bit is at bit 0.
- out_valid  out  1  out_data holds an unconsumed word.
- bit_err  out  1  one-cycle pulse when a sample is rejected.
- err_cnt  out  8  count of rejected samples; saturates at 255.
- ovf  out  1  sticky: a sample arrived while the block was in HOLD.

Behaviour:
- Reset (asynchronous assert, synchronous-release use): all synchronizer flops, shift register, bit counter and stability counter go to 0. out_data=0, out_valid=0, bit_err=0, err_cnt=0, ovf=0. State=FILL.
- Synchronization:
  - qa and qb each pass through SYNC_STAGES flops, giving qa_s/qb_s.
  - sample_en and all logic act on qa_s/qb_s; sample_en carries no synchronizer delay.
- Stability (define valid_s = qa_s ^ qb_s; stab is a 4-bit counter):
  - If valid_s=0: stab_nxt=0.
  - Else if qa_s equals the previous qa_s and the previous valid_s was 1: stab_nxt=min(stab+1,15).
  - Otherwise: stab_nxt=1.
- Sample accept condition: sample_en && stab_nxt>=STABLE_CYC && state==FILL.
  - Accepted bit qa_s is shifted in LSB-first: shreg <= {qa_s, shreg[WORD_W-1:1]}; bit_cnt increments.
- Sample reject: sample_en && state==FILL && stab_nxt<STABLE_CYC.
  - Bit discarded; bit_cnt unchanged.
  - bit_err pulses 1 on the next cycle; err_cnt increments, saturating.
- FSM:
  - FILL: collect bits. When an accept brings bit_cnt to WORD_W:
    - If the output slot is free (out_valid=0, or out_valid&&out_ready this cycle): move the word to out_data, assert out_valid next cycle, clear bit_cnt, stay in FILL.
    - Otherwise go to HOLD.
  - HOLD: the completed word waits in shreg. When out_valid&&out_ready: load out_data from shreg next cycle, keep out_valid=1, clear bit_cnt, return to FILL.
- Handshake:
  - out_data and out_valid are registered and stable while out_valid&&!out_ready.
  - out_valid drops the cycle after the transfer unless a new word is loaded in the same cycle.
  - Back-to-back words are sustained with no bubble.
- Overflow: sample_en while in HOLD sets ovf=1 (sticky). The bit is dropped; it counts as neither an error nor an accept.
- clr_err:
  - Clears ovf and err_cnt the next cycle.
  - If clr_err coincides with a reject: err_cnt=1.
  - If clr_err coincides with an overflow event: ovf stays 1.
- Reset mid-word: a partial word is lost and not emitted. An asserted out_valid drops immediately (asynchronously).
- Latency:
  - A qa/qb edge is visible to sampling after SYNC_STAGES cycles.
  - The final accepted bit appears in out_data 1 cycle later when the slot is free.

Test Plan:
- Reset and idle: rst_n=0 with qa=1, qb=0 → all outputs 0; release, no sample_en → out_valid stays 0.
- Word pack: hold each bit ≥4 cycles, strobe the bit pattern 1,0,1,1,0,0,1,0, out_ready=1 → out_data=8'h4D, out_valid high exactly 1 cycle, err_cnt=0.
- Invalid latch state: qa=qb=1 during the 3rd strobe → bit_err pulse, err_cnt=1, that bit not shifted. Nine strobes then yield one word from the 8 valid bits.
- Stability: qa/qb flip 1 cycle before a strobe (STABLE_CYC=2) → rejected, err_cnt+1. Same flip 3 cycles before → accepted.
- Backpressure/overflow: out_ready=0, send 16 valid bits → word 1 held; word 2 completes and the block enters HOLD. 17th strobe sets ovf=1. Assert out_ready → word 1 then word 2, back-to-back. Pulse clr_err → ovf=0, err_cnt=0.
- Reset mid-operation: assert rst_n=0 after 5 bits → out_valid=0 immediately. After release, the next 8 bits form a clean word with no residue.
